// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states, FIFO entry width and legal parameter limits for uart_rx_ovs.
// UART_RX_PARITY_EN adds the PARITY state and a parity-error bit to each FIFO entry.
package uart_rx_pkg;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;
    localparam int OVERSAMPLE_LO = 8;
    localparam int OVERSAMPLE_HI = 16;
    localparam int STOP_BITS_MAX = 2;
    localparam int FIFO_DEPTH_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        PUSH
    } rx_state_t;

    // Entry layout is {data, frame_err[, parity_err]}.
    function automatic int entry_width(input int data_bits);
`ifdef UART_RX_PARITY_EN
        return data_bits + 2;
`else
        return data_bits + 1;
`endif
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: frame FIFO with registered head/valid, drop-on-full and a one-cycle overrun pulse.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             r_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp, wp_n, rp_n;
    logic full, wr, rd;
    assign full = wp == {~rp[AW], rp[AW-1:0]};
    assign rd = pop & valid;
    assign wr = push & (~full | rd);
    assign wp_n = wp + (AW+1)'(wr);
    assign rp_n = rp + (AW+1)'(rd);
    always_ff @(posedge r_clk) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            dout <= '0;
            valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            wp <= wp_n;
            rp <= rp_n;
            valid <= wp_n != rp_n;
            // Bypass lets a push into an empty FIFO appear at the head one cycle later.
            dout <= (wr && wp[AW-1:0] == rp_n[AW-1:0]) ? din : mem[rp_n[AW-1:0]];
            overrun <= push & full & ~rd;
        end
    end
    always_ff @(posedge r_clk) begin
        if (wr) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with 2-flop synchroniser, mid-bit sampling and frame FIFO.
// Define UART_RX_PARITY_EN to enable the parity bit and parameter PARITY_ODD.
module uart_rx_ovs
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLKS_PER_TICK = 27,
    parameter int STOP_BITS = 1,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD = 0,
`endif
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 r_clk,
    input  logic                 reset,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int EW = entry_width(DATA_BITS);
    localparam int DW = $clog2(CLKS_PER_TICK + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    rx_state_t state;
    logic [1:0] sync;
    logic rx, rx_prev, tick, samp, push, ferr;
    logic [DW-1:0] div;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [EW-1:0] entry, head;
    assign rx = sync[1];
    assign rx_busy = state != IDLE;
    assign push = state == PUSH;
    assign tick = rx_busy && div == DW'(CLKS_PER_TICK - 1);
    // Start bit is checked at half a bit; every later sample is one full bit on, i.e. mid-bit.
    assign samp = tick && tcnt == TW'(state == START ? OVERSAMPLE / 2 - 1 : OVERSAMPLE - 1);
    always_ff @(posedge r_clk) begin
        if (!reset) begin
            sync <= 2'b11;
            rx_prev <= 1'b1;
            div <= '0;
        end else begin
            sync <= {sync[0], data_in};
            rx_prev <= rx;
            div <= (!rx_busy || div == DW'(CLKS_PER_TICK - 1)) ? '0 : div + 1'b1;
        end
    end
`ifdef UART_RX_PARITY_EN
    logic perr;
    assign entry = {shreg, ferr, perr};
    assign frame_err = rx_valid & head[1];
    assign parity_err = rx_valid & head[0];
`else
    assign entry = {shreg, ferr};
    assign frame_err = rx_valid & head[0];
    assign parity_err = 1'b0;
`endif
    assign data_out = head[EW-1 -: DATA_BITS];
    always_ff @(posedge r_clk) begin
        if (!reset) begin
            state <= IDLE;
            tcnt <= '0;
            bcnt <= '0;
            shreg <= '0;
            ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            tcnt <= (!rx_busy || samp) ? '0 : tick ? tcnt + 1'b1 : tcnt;
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    if (rx_prev && !rx) begin
                        state <= START;
                        ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr <= 1'b0;
`endif
                    end
                end
                START: if (samp) state <= rx ? IDLE : DATA;
                DATA: if (samp) begin
                    shreg <= {rx, shreg[DATA_BITS-1:1]};
                    bcnt <= bcnt == BW'(DATA_BITS - 1) ? '0 : bcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bcnt == BW'(DATA_BITS - 1)) state <= PARITY;
                end
                PARITY: if (samp) begin
                    perr <= (^shreg ^ rx) != PARITY_ODD[0];
                    state <= STOP;
`else
                    if (bcnt == BW'(DATA_BITS - 1)) state <= STOP;
`endif
                end
                STOP: if (samp) begin
                    ferr <= ferr | ~rx;
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == BW'(STOP_BITS - 1)) state <= PUSH;
                end
                PUSH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .r_clk(r_clk),
        .reset(reset),
        .push(push),
        .din(entry),
        .pop(rx_ready),
        .dout(head),
        .valid(rx_valid),
        .overrun(overrun)
    );
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed bench for uart_rx_ovs at 4 clocks/tick, 16 ticks/bit (64 clocks per bit).
module tb_uart_rx_ovs;
    localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic r_clk = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b1;
    logic rx_ready = 1'b0;
    logic [7:0] data_out;
    logic rx_valid, frame_err, parity_err, overrun, rx_busy;
    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;

    uart_rx_ovs #(
        .DATA_BITS(8),
        .OVERSAMPLE(16),
        .CLKS_PER_TICK(4),
        .STOP_BITS(1),
        .FIFO_DEPTH(4)
    ) dut (
        .r_clk(r_clk),
        .reset(reset),
        .data_in(data_in),
        .data_out(data_out),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun(overrun),
        .rx_busy(rx_busy)
    );

    always #5 r_clk = ~r_clk;

    always @(negedge r_clk) if (overrun === 1'b1) ovr_cnt++;

    function automatic logic [10:0] frm(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
        return {stop, ^d, d, 1'b0};
`else
        return {1'b0, stop, d, 1'b0};
`endif
    endfunction

    // Serialises bits LSB first, then one idle bit; reset drops at bit rst_at and rises at the end.
    task automatic send_bits(input logic [10:0] bits, input int n, input int rst_at);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) reset = 1'b0;
            data_in = bits[i];
            repeat (BIT) @(negedge r_clk);
        end
        data_in = 1'b1;
        repeat (BIT) @(negedge r_clk);
        reset = 1'b1;
    endtask

    task automatic pop_one;
        rx_ready = 1'b1;
        @(negedge r_clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (5) @(negedge r_clk);
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data_out); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        reset = 1'b1;
        repeat (5) @(negedge r_clk);
    endtask

    task automatic test_basic;
        send_bits(frm(8'h41, 1'b1), NB, -1);
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
        tests++; if (data_out !== 8'h41) begin fails++; $display("FAIL basic_data: got %h expected 41", data_out); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL basic_ferr: got %b expected 0", frame_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL basic_perr: got %b expected 0", parity_err); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", rx_busy); end
        pop_one();
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_pop_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_glitch;
        data_in = 1'b0;
        repeat (10) @(negedge r_clk);
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start: got %b expected 1", rx_busy); end
        repeat (10) @(negedge r_clk);
        data_in = 1'b1;
        repeat (BIT) @(negedge r_clk);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %b expected 0", rx_busy); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_frame_err;
        send_bits(frm(8'h55, 1'b0), NB, -1);
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ferr_valid: got %b expected 1", rx_valid); end
        tests++; if (data_out !== 8'h55) begin fails++; $display("FAIL ferr_data: got %h expected 55", data_out); end
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
        pop_one();
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_after_pop: got %b expected 0", frame_err); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        send_bits({1'b1, 1'b1, 8'h03, 1'b0}, NB, -1);
        tests++; if (data_out !== 8'h03) begin fails++; $display("FAIL par_bad_data: got %h expected 03", data_out); end
        tests++; if (parity_err !== 1'b1) begin fails++; $display("FAIL par_bad_flag: got %b expected 1", parity_err); end
        pop_one();
        send_bits({1'b1, 1'b0, 8'h03, 1'b0}, NB, -1);
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL par_good_valid: got %b expected 1", rx_valid); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL par_good_flag: got %b expected 0", parity_err); end
        pop_one();
    endtask
`endif

    task automatic test_overrun;
        logic [7:0] exp;
        ovr_cnt = 0;
        for (int i = 0; i < 4; i++) send_bits(frm(8'h10 + 8'(i), 1'b1), NB, -1);
        tests++; if (ovr_cnt !== 0) begin fails++; $display("FAIL ovr_before: got %0d expected 0", ovr_cnt); end
        send_bits(frm(8'h14, 1'b1), NB, -1);
        tests++; if (ovr_cnt !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid%0d: got %b expected 1", i, rx_valid); end
            tests++; if (data_out !== exp) begin fails++; $display("FAIL ovr_data%0d: got %h expected %h", i, data_out, exp); end
            pop_one();
        end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_drained: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame;
        send_bits(frm(8'hA5, 1'b1), NB, 4);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
        repeat (4) @(negedge r_clk);
        send_bits(frm(8'h5A, 1'b1), NB, -1);
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL midrst_next_valid: got %b expected 1", rx_valid); end
        tests++; if (data_out !== 8'h5A) begin fails++; $display("FAIL midrst_next_data: got %h expected 5a", data_out); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL midrst_next_ferr: got %b expected 0", frame_err); end
        pop_one();
    endtask

    initial begin
        @(negedge r_clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
